// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: datapath width, register address width and
// the operand stage occupancy states.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

  typedef enum logic {
    StEmpty,
    StFull
  } stage_state_e;

  // Register 0 is hardwired to zero, so it never matches a pending write.
  function automatic logic addr_hit(logic we, reg_addr_t wa, reg_addr_t ra);
    return we && (wa == ra) && (ra != '0);
  endfunction

endpackage

// File: rtl/operand_stage_if.sv
// Decode-side, register file, bypass and execute-side signals of the operand stage.
interface operand_stage_if;
  import cpu_pkg::*;

  logic      in_valid;
  logic      in_ready;
  reg_addr_t in_rs;
  reg_addr_t in_rt;
  reg_addr_t in_rd;
  logic      in_we;

  reg_addr_t ra1;
  reg_addr_t ra2;
  xlen_t     rd1;
  xlen_t     rd2;

  logic      wb_we;
  reg_addr_t wb_wa;
  xlen_t     wb_wd;

  logic      ex_we;
  reg_addr_t ex_wa;
  xlen_t     ex_wd;
  logic      ex_load;

  logic      flush;

  logic      out_valid;
  logic      out_ready;
  xlen_t     out_a;
  xlen_t     out_b;
  reg_addr_t out_rd;
  logic      out_we;

  logic [31:0] stall_cnt;

  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_we, rd1, rd2,
    input  wb_we, wb_wa, wb_wd, ex_we, ex_wa, ex_wd, ex_load, flush, out_ready,
    output in_ready, ra1, ra2, out_valid, out_a, out_b, out_rd, out_we, stall_cnt
  );

  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_we, rd1, rd2,
    output wb_we, wb_wa, wb_wd, ex_we, ex_wa, ex_wd, ex_load, flush, out_ready,
    input  in_ready, ra1, ra2, out_valid, out_a, out_b, out_rd, out_we, stall_cnt
  );

endinterface

// File: rtl/bypass_mux.sv
// Single-source operand select: zero register, then EX, then WB, then register file.
// The EX path exists only when OPERAND_STAGE_EX_FWD_EN is defined.
module bypass_mux
  import cpu_pkg::*;
(
  input  reg_addr_t ra_i,
  input  xlen_t     rf_i,
  input  logic      ex_we_i,
  input  reg_addr_t ex_wa_i,
  input  xlen_t     ex_wd_i,
  input  logic      wb_we_i,
  input  reg_addr_t wb_wa_i,
  input  xlen_t     wb_wd_i,
  output xlen_t     data_o,
  output logic      ex_hit_o
);

  logic wb_hit;

  assign ex_hit_o = addr_hit(ex_we_i, ex_wa_i, ra_i);
  assign wb_hit   = addr_hit(wb_we_i, wb_wa_i, ra_i);

  always_comb begin
    data_o = rf_i;
    if (ra_i == '0) begin
      data_o = '0;
`ifdef OPERAND_STAGE_EX_FWD_EN
    end else if (ex_hit_o) begin
      data_o = ex_wd_i;
`endif
    end else if (wb_hit) begin
      data_o = wb_wd_i;
    end
  end

`ifndef OPERAND_STAGE_EX_FWD_EN
  logic unused_ex_wd;
  assign unused_ex_wd = ^ex_wd_i;
`endif

endmodule

// File: rtl/operand_stage.sv
// Operand fetch stage: bypassed register reads, load-use stall and a one-entry output register.
// OPERAND_STAGE_EX_FWD_EN enables forwarding from execute; otherwise any EX match stalls.
module operand_stage
  import cpu_pkg::*;
(
  input logic            clk,
  input logic            rst,
  operand_stage_if.slave bus_io
);

  stage_state_e state_q, state_d;
  xlen_t        a_q, a_d;
  xlen_t        b_q, b_d;
  reg_addr_t    rd_q, rd_d;
  logic         we_q, we_d;
  logic [31:0]  stall_q, stall_d;

  xlen_t opnd_a, opnd_b;
  logic  ex_hit_a, ex_hit_b;
  logic  hazard, in_ready, transfer, out_valid;

  assign bus_io.ra1 = bus_io.in_rs;
  assign bus_io.ra2 = bus_io.in_rt;

  bypass_mux u_mux_a (
    .ra_i    (bus_io.in_rs),
    .rf_i    (bus_io.rd1),
    .ex_we_i (bus_io.ex_we),
    .ex_wa_i (bus_io.ex_wa),
    .ex_wd_i (bus_io.ex_wd),
    .wb_we_i (bus_io.wb_we),
    .wb_wa_i (bus_io.wb_wa),
    .wb_wd_i (bus_io.wb_wd),
    .data_o  (opnd_a),
    .ex_hit_o(ex_hit_a)
  );

  bypass_mux u_mux_b (
    .ra_i    (bus_io.in_rt),
    .rf_i    (bus_io.rd2),
    .ex_we_i (bus_io.ex_we),
    .ex_wa_i (bus_io.ex_wa),
    .ex_wd_i (bus_io.ex_wd),
    .wb_we_i (bus_io.wb_we),
    .wb_wa_i (bus_io.wb_wa),
    .wb_wd_i (bus_io.wb_wd),
    .data_o  (opnd_b),
    .ex_hit_o(ex_hit_b)
  );

`ifdef OPERAND_STAGE_EX_FWD_EN
  // Only a load in execute cannot be forwarded yet.
  assign hazard = bus_io.in_valid && (ex_hit_a || ex_hit_b) && bus_io.ex_load;
`else
  assign hazard = bus_io.in_valid && (ex_hit_a || ex_hit_b);
  logic unused_ex_load;
  assign unused_ex_load = bus_io.ex_load;
`endif

  assign out_valid = (state_q == StFull);
  assign in_ready  = !rst && !hazard && (!out_valid || bus_io.out_ready) && !bus_io.flush;
  assign transfer  = bus_io.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    we_d    = we_q;
    stall_d = stall_q;

    if (bus_io.flush) begin
      state_d = StEmpty;
    end else if (transfer) begin
      state_d = StFull;
      a_d     = opnd_a;
      b_d     = opnd_b;
      rd_d    = bus_io.in_rd;
      we_d    = bus_io.in_we;
    end else if (out_valid && bus_io.out_ready) begin
      state_d = StEmpty;
    end

    if (hazard && !bus_io.flush) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      stall_q <= stall_d;
    end
  end

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = out_valid;
  assign bus_io.out_a     = a_q;
  assign bus_io.out_b     = b_q;
  assign bus_io.out_rd    = rd_q;
  assign bus_io.out_we    = we_q;
  assign bus_io.stall_cnt = stall_q;

endmodule

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: directed scenarios followed by random traffic
// against a register-file model with bypass resolved from first principles.
module tb_operand_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  operand_stage_if bus ();

  operand_stage dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] rf [32];
  exp_t        q [$];
  logic        exp_valid = 1'b0;
  logic        exp_rdy   = 1'b0;
  logic        prev_rst  = 1'b0;
  logic        mon_en    = 1'b0;
  logic [31:0] exp_stall = '0;
  int          n_cmp     = 0;
  int          n_fail    = 0;

  function automatic logic ex_match(logic [4:0] a);
    return bus.ex_we && (bus.ex_wa == a) && (a != 5'd0);
  endfunction

  // Value an instruction should see for source a in the current cycle.
  function automatic logic [31:0] resolve(logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef OPERAND_STAGE_EX_FWD_EN
    if (ex_match(a)) return bus.ex_wd;
`endif
    if (bus.wb_we && bus.wb_wa == a) return bus.wb_wd;
    return rf[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue the inputs currently on the bus for one clock and advance the model.
  task automatic cycle();
    logic hz, inc, was_rst;
    exp_t e;
    bus.rd1 = rf[bus.in_rs];
    bus.rd2 = rf[bus.in_rt];
`ifdef OPERAND_STAGE_EX_FWD_EN
    hz = bus.in_valid && (ex_match(bus.in_rs) || ex_match(bus.in_rt)) && bus.ex_load;
`else
    hz = bus.in_valid && (ex_match(bus.in_rs) || ex_match(bus.in_rt));
`endif
    exp_valid = (q.size() != 0);
    exp_rdy   = !rst && !hz && !bus.flush && (!exp_valid || bus.out_ready);
    if (bus.in_valid && exp_rdy) begin
      e.a  = resolve(bus.in_rs);
      e.b  = resolve(bus.in_rt);
      e.rd = bus.in_rd;
      e.we = bus.in_we;
      q.push_back(e);
    end
    inc     = hz && !bus.flush;
    was_rst = rst;
    @(posedge clk);
    #1;
    if (was_rst) exp_stall = 32'd0;
    else if (inc) exp_stall = exp_stall + 32'd1;
    if (bus.wb_we && bus.wb_wa != 5'd0) rf[bus.wb_wa] = bus.wb_wd;
    prev_rst = was_rst;
  endtask

  task automatic idle_inputs();
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_rs     = 5'd0;
    bus.in_rt     = 5'd0;
    bus.in_rd     = 5'd0;
    bus.in_we     = 1'b0;
    bus.wb_we     = 1'b0;
    bus.wb_wa     = 5'd0;
    bus.wb_wd     = 32'd0;
    bus.ex_we     = 1'b0;
    bus.ex_wa     = 5'd0;
    bus.ex_wd     = 32'd0;
    bus.ex_load   = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
    bus.in_we    = 1'b1;
  endtask

  // Monitor: compare DUT against the scoreboard head, then retire on drain/flush/reset.
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
      check("ra1", {27'd0, bus.ra1}, {27'd0, bus.in_rs});
      check("ra2", {27'd0, bus.ra2}, {27'd0, bus.in_rt});
      check("stall_cnt", bus.stall_cnt, exp_stall);
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
      if (exp_valid && q.size() != 0) begin
        check("out_a", bus.out_a, q[0].a);
        check("out_b", bus.out_b, q[0].b);
        check("out_rd", {27'd0, bus.out_rd}, {27'd0, q[0].rd});
        check("out_we", {31'd0, bus.out_we}, {31'd0, q[0].we});
      end
      if (prev_rst) begin
        check("rst_out_a", bus.out_a, 32'd0);
        check("rst_out_b", bus.out_b, 32'd0);
        check("rst_out_rd", {27'd0, bus.out_rd}, 32'd0);
        check("rst_out_we", {31'd0, bus.out_we}, 32'd0);
      end
      if (rst || bus.flush) q.delete();
      else if (exp_valid && bus.out_ready) void'(q.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    idle_inputs();
    bus.rd1 = 32'd0;
    bus.rd2 = 32'd0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    prev_rst = 1'b1;
    mon_en   = 1'b1;
    rst      = 1'b0;

    // Plain register file read.
    rf[3] = 32'h11;
    issue(5'd3, 5'd0, 5'd9);
    cycle();
    idle_inputs();
    cycle();

    // WB bypass beats stale read data; zero register ignores WB.
    rf[5] = 32'h0;
    issue(5'd5, 5'd0, 5'd1);
    bus.wb_we = 1'b1; bus.wb_wa = 5'd5; bus.wb_wd = 32'hAB;
    cycle();
    idle_inputs();
    issue(5'd1, 5'd0, 5'd2);
    bus.wb_we = 1'b1; bus.wb_wa = 5'd0; bus.wb_wd = 32'hFF;
    cycle();
    idle_inputs();
    cycle();

    // Load-use stall, then forwarded result.
    rst = 1'b1;
    cycle();
    idle_inputs();
    issue(5'd7, 5'd2, 5'd3);
    bus.ex_we = 1'b1; bus.ex_wa = 5'd7; bus.ex_load = 1'b1; bus.ex_wd = 32'hDEAD;
    cycle();
    bus.ex_load = 1'b0; bus.ex_wd = 32'h42;
    cycle();
    idle_inputs();
    cycle();

    // Backpressure while full, then drain and refill with no bubble.
    issue(5'd4, 5'd6, 5'd4);
    cycle();
    bus.out_ready = 1'b0;
    issue(5'd8, 5'd9, 5'd5);
    for (int i = 0; i < 3; i++) cycle();
    bus.out_ready = 1'b1;
    cycle();
    idle_inputs();
    cycle();

    // Flush and reset while full.
    issue(5'd10, 5'd11, 5'd6);
    bus.out_ready = 1'b0;
    cycle();
    bus.flush = 1'b1;
    cycle();
    idle_inputs();
    bus.out_ready = 1'b0;
    issue(5'd12, 5'd13, 5'd7);
    cycle();
    rst = 1'b1;
    cycle();
    idle_inputs();
    cycle();

    // Random traffic over a small register window to provoke matches.
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 99) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_rs     = 5'($urandom_range(0, 7));
      bus.in_rt     = 5'($urandom_range(0, 7));
      bus.in_rd     = 5'($urandom_range(0, 31));
      bus.in_we     = 1'($urandom_range(0, 1));
      bus.wb_we     = 1'($urandom_range(0, 1));
      bus.wb_wa     = 5'($urandom_range(0, 7));
      bus.wb_wd     = $urandom;
      bus.ex_we     = 1'($urandom_range(0, 1));
      bus.ex_wa     = 5'($urandom_range(0, 7));
      bus.ex_wd     = $urandom;
      bus.ex_load   = ($urandom_range(0, 3) == 0);
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
